// File: rtl/alu_pkg.sv
// Types and constants shared between the ALU and its requester-side sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_CMP = 2'b01,
    OP_SHL = 2'b10,
    OP_CHG = 2'b11
  } op_e;

  // Bit positions inside the 4-bit {carry, err, even, single} flag vector
  localparam int unsigned FLG_CARRY  = 3;
  localparam int unsigned FLG_ERR    = 2;
  localparam int unsigned FLG_EVEN   = 1;
  localparam int unsigned FLG_SINGLE = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_sat_counter.sv
// Event counter with optional saturation at all-ones; wraps when saturation is disabled.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(sat_en && at_max)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Requester side of the ALU interface: takes one command, holds operands for SETTLE cycles,
// captures result and flags, presents them on a valid/ready port and counts completions.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [BITS-1:0]  i_cmd_a,
  input  logic [BITS-1:0]  i_cmd_b,
  input  logic [1:0]       i_cmd_op,
  output logic [BITS-1:0]  o_alu_a,
  output logic [BITS-1:0]  o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic [BITS-1:0]  i_alu_out,
  input  logic [3:0]       i_alu_flags,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [BITS-1:0]  o_res_data,
  output logic [3:0]       o_res_flags,
  output logic [CNT_W-1:0] o_op_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e    state;
  logic [CW-1:0] settle_cnt;
  logic          res_done;
  logic          err_done;

  // Ready depends on state alone, so a result handshake never doubles as an accept
  assign o_cmd_ready = (state == IDLE);
  assign res_done    = (state == RESP) && i_res_ready;
  assign err_done    = res_done && o_res_flags[FLG_ERR];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_alu_a    <= i_cmd_a;
            o_alu_b    <= i_cmd_b;
            o_alu_op   <= i_cmd_op;
            settle_cnt <= CW'(SETTLE - 1);
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (settle_cnt == '0) begin
            o_res_data  <= i_alu_out;
            o_res_flags <= i_alu_flags;
            o_res_valid <= 1'b1;
            state       <= RESP;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        RESP: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_op_cnt (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .inc    (res_done),
    .sat_en (1'b0),
    .count  (o_op_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .inc    (err_done),
    .sat_en (1'b1),
    .count  (o_err_cnt)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-level model plus directed vectors on SETTLE=1 and SETTLE=3.
module tb_alu_sequencer;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_op;
  logic [3:0] alu_flags;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic [7:0] op_cnt, err_cnt;
  logic       force_err;

  logic       c3_valid, c3_ready_o;
  logic [7:0] c3_a, c3_b;
  logic [1:0] c3_op;
  logic [7:0] c3_alu_a, c3_alu_b, c3_alu_out;
  logic [1:0] c3_alu_op;
  logic [3:0] c3_alu_flags;
  logic       c3_res_valid, c3_res_ready;
  logic [7:0] c3_res_data;
  logic [3:0] c3_res_flags;
  logic [7:0] c3_op_cnt, c3_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: returns {carry, err, even, single, out}
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op, input logic ferr);
    logic [7:0] o;
    logic       c;
    case (op)
      2'b00:   begin o = a - b; c = (a < b); end
      2'b01:   begin o = (a < b) ? 8'hFF : ((a == b) ? 8'h00 : 8'h01); c = (a < b); end
      2'b10:   begin o = {a[6:0], 1'b0}; c = a[7]; end
      default: begin o = ~a; c = 1'b0; end
    endcase
    return {c, ferr, (a == b), (o == 8'hFF), o};
  endfunction

  assign {alu_flags, alu_out}       = alu_f(alu_a, alu_b, alu_op, force_err);
  assign {c3_alu_flags, c3_alu_out} = alu_f(c3_alu_a, c3_alu_b, c3_alu_op, 1'b0);

  alu_sequencer #(.BITS(8), .SETTLE(S), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_op(cmd_op),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_out(alu_out), .i_alu_flags(alu_flags),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_res_flags(res_flags), .o_op_cnt(op_cnt), .o_err_cnt(err_cnt)
  );

  alu_sequencer #(.BITS(8), .SETTLE(3), .CNT_W(8)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(c3_valid), .o_cmd_ready(c3_ready_o),
    .i_cmd_a(c3_a), .i_cmd_b(c3_b), .i_cmd_op(c3_op),
    .o_alu_a(c3_alu_a), .o_alu_b(c3_alu_b), .o_alu_op(c3_alu_op),
    .i_alu_out(c3_alu_out), .i_alu_flags(c3_alu_flags),
    .o_res_valid(c3_res_valid), .i_res_ready(c3_res_ready), .o_res_data(c3_res_data),
    .o_res_flags(c3_res_flags), .o_op_cnt(c3_op_cnt), .o_err_cnt(c3_err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the SETTLE=1 instance
  logic       m_busy = 1'b0, m_has = 1'b0;
  int         m_age = 0, m_opc = 0, m_errc = 0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;
  logic [1:0] m_op = '0;
  logic [3:0] m_flags = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_has <= 1'b0; m_age <= 0; m_opc <= 0; m_errc <= 0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_flags <= '0;
    end else if (m_has) begin
      if (res_ready) begin
        m_has  <= 1'b0;
        m_busy <= 1'b0;
        m_opc  <= (m_opc + 1) % 256;
        if (m_flags[2]) m_errc <= (m_errc >= 255) ? 255 : m_errc + 1;
      end
    end else if (m_busy) begin
      if (m_age + 1 == S) begin
        {m_flags, m_res} <= alu_f(m_a, m_b, m_op, force_err);
        m_has <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (cmd_valid) begin
      m_a <= cmd_a; m_b <= cmd_b; m_op <= cmd_op;
      m_busy <= 1'b1;
      m_age  <= 0;
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("res_valid", res_valid, m_has);
    chk("res_data", res_data, m_res);
    chk("res_flags", res_flags, m_flags);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    chk("op_cnt", op_cnt, m_opc);
    chk("err_cnt", err_cnt, m_errc);
  end

  time acc_t[$];
  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) acc_t.push_back($time);

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    res_ready = 1'b1; force_err = 1'b0;
    c3_valid = 1'b0; c3_a = '0; c3_b = '0; c3_op = '0; c3_res_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_opcnt", op_cnt, 8'h00);

    // SUB 5-3 with consumer ready
    cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = 2'b00;
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("sub_busy", cmd_ready, 1'b0);
    chk("sub_nores", res_valid, 1'b0);
    step();
    @(negedge clk);
    chk("sub_valid", res_valid, 1'b1);
    chk("sub_data", res_data, 8'h02);
    chk("sub_flags", res_flags, 4'b0000);
    step();
    @(negedge clk);
    chk("sub_opcnt", op_cnt, 8'h01);
    chk("sub_idle", cmd_ready, 1'b1);

    // Backpressure: result held, new commands ignored
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'hA0; cmd_b = 8'h0F; cmd_op = 2'b10;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_data", res_data, 8'h40);
      chk("bp_flags", res_flags, 4'b1000);
      chk("bp_ready", cmd_ready, 1'b0);
      chk("bp_alu_a", alu_a, 8'hA0);
      step();
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_opcnt", op_cnt, 8'h02);

    // Async reset in the middle of ISSUE
    cmd_valid = 1'b1; cmd_a = 8'h33; cmd_b = 8'h01; cmd_op = 2'b11;
    step();
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", cmd_ready, 1'b1);
    chk("ar_valid", res_valid, 1'b0);
    chk("ar_alu_a", alu_a, 8'h00);
    chk("ar_opcnt", op_cnt, 8'h00);
    chk("ar_data", res_data, 8'h00);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("ar_nores", res_valid, 1'b0);

    // SETTLE=3 instance: operands held three cycles before capture
    c3_valid = 1'b1; c3_a = 8'h40; c3_b = 8'h40; c3_op = 2'b01;
    step();
    c3_valid = 1'b0; c3_a = 8'hFF; c3_b = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s3_alu_a", c3_alu_a, 8'h40);
      chk("s3_alu_b", c3_alu_b, 8'h40);
      chk("s3_nores", c3_res_valid, 1'b0);
      step();
    end
    @(negedge clk);
    chk("s3_valid", c3_res_valid, 1'b1);
    chk("s3_data", c3_res_data, 8'h00);
    chk("s3_flags", c3_res_flags, 4'b0010);
    step();
    @(negedge clk);
    chk("s3_opcnt", c3_op_cnt, 8'h01);

    // Counter saturation and wrap with ERR forced
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    force_err = 1'b1;
    cmd_a = 8'h09; cmd_b = 8'h04; cmd_op = 2'b00;
    for (int i = 0; i < 255; i++) begin
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      repeat (2) step();
    end
    @(negedge clk);
    chk("sat_op255", op_cnt, 8'hFF);
    chk("sat_err255", err_cnt, 8'hFF);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("wrap_op", op_cnt, 8'h00);
    chk("sat_err", err_cnt, 8'hFF);
    force_err = 1'b0;

    // Back-to-back with valid held high
    acc_t.delete();
    for (int i = 0; i < 30; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(i * 7); cmd_b = 8'(i * 3); cmd_op = 2'(i);
      step();
    end
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("b2b_count", acc_t.size(), 10);
    for (int i = 1; i < acc_t.size(); i++) chk("b2b_gap", 32'(acc_t[i] - acc_t[i-1]), 30);
    @(negedge clk);
    chk("b2b_opcnt", op_cnt, 8'h0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
